uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It detects each completed character from the receiver's `rx_data`/`rx_status` pair and pushes it into a circular FIFO. It offers a read-enable pop interface with level flags and a sticky overflow flag to the CPU-side consumer. Its purpose is to decouple character arrival (one byte per 160 clocks at 16x oversampling) from bursty software reads.

## Interface
Parameters:
- `DEPTH`, default 16: number of byte entries. Must be a power of two, at least 2.
- `AW`, default `$clog2(DEPTH)`: pointer width. Derived; not overridden.

Ports:
- `clk`, input, 1: system clock, same clock as the receiver.
- `rst`, input, 1: asynchronous, active-high reset.
- `rx_data`, input, 8: received byte from the receiver. Stable whenever `rx_status` is 1.
- `rx_status`, input, 1: receiver done level. A 0→1 transition marks a new byte.
- `rd_en`, input, 1: pop request from the consumer.
- `rd_data`, output, 8: read data.
- `rd_valid`, output, 1: `rd_data` is valid this cycle.
- `empty`, output, 1: FIFO holds 0 entries.
- `full`, output, 1: FIFO holds `DEPTH` entries.
- `count`, output, AW+1: current occupancy, 0..DEPTH.
- `overflow`, output, 1: sticky flag; a byte was dropped.
- `ovf_clr`, input, 1: clears `overflow`.

## Operation
- Edge detect:
  - `st_d` is a register of `rx_status`.
  - `push = rx_status & ~st_d`, evaluated on the same cycle; `rx_data` is captured on that edge.
  - Exactly one push per character, however long `rx_status` stays high.
- Storage:
  - `wr_ptr` and `rd_ptr` are AW+1 bits wide, and the MSB is the wrap bit.
  - `empty` when the pointers are equal.
  - `full` when the low bits are equal and the MSBs differ.
  - `count = wr_ptr - rd_ptr`, computed modulo 2^(AW+1).
- Pop:
  - `pop = rd_en & ~empty`.
  - `rd_en` while empty is ignored: no pointer change, `rd_valid` stays 0.
- Push and pop on the same cycle:
  - Both are performed and `count` is unchanged.
  - This includes the full case: the byte is accepted and `overflow` is not set.
  - It also includes the non-empty case.
- Push while empty with `rd_en` on the same cycle: only the push takes effect. There is no read-through.
- Overflow:
  - A push while full with no pop drops the byte, leaves the pointers unchanged, and sets `overflow`.
  - `ovf_clr` clears `overflow`.
  - If `ovf_clr` and a new drop occur in the same cycle, `overflow` stays 1 (set wins).
- Reset values:
  - Pointers 0, `count` 0, `empty` 1, `full` 0, `overflow` 0, `rd_valid` 0, `rd_data` 8'h00.
  - `st_d` resets to 1, so that a `rx_status` already high at reset release is not pushed as a stale byte.
- Reset mid-operation: contents are discarded and the flags return to their reset values immediately (asynchronously).

## Timing
- Push latency:
  - A byte present at edge N (first cycle with `rx_status` high) is stored at edge N.
  - `empty` deasserts and `count` increments after edge N.
- `empty`, `full` and `count` are registered and reflect all pushes and pops of the previous edge.
- Read latency depends on `UART_RX_FIFO_FWFT_EN`; see Configuration.
- Sustained throughput is one pop per cycle. Pushes are at most one per character time.

## Configuration
`UART_RX_FIFO_FWFT_EN` selects first-word-fall-through:
- Defined (FWFT):
  - `rd_data` continuously shows the head entry, and `rd_valid = ~empty`.
  - `rd_en` acknowledges and pops the entry; the next head appears on the following cycle.
- Undefined (standard):
  - `rd_data` is registered. A pop at edge N loads the head entry into `rd_data` at edge N.
  - `rd_valid` is 1 for exactly that one cycle.
  - `rd_data` holds its value otherwise.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W = 8`, plus a `uart_byte_t` typedef.
  - Shared with the transmitter and the receiver.
- Sub-module `uart_fifo_mem`:
  - `DEPTH`×8 storage with a synchronous write port and an asynchronous read port.
  - It contains no flags.
- Pointer and flag logic, the edge detector and the FWFT select stay in `uart_rx_fifo`.

## Test plan
- **Reset release with `rx_status` held high:** after reset, `rx_status`=1 and `rx_data`=8'hA5 → no push; `empty`=1, `count`=0.
- **Single byte:** pulse `rx_status` 0→1 with `rx_data`=8'h41 and hold it high for 20 cycles → exactly one entry, `count`=1.
  - Standard mode: `rd_en` for 1 cycle → `rd_data`=8'h41 with `rd_valid` for 1 cycle, then `empty`=1.
  - FWFT mode: 8'h41 is visible before `rd_en`.
- **Fill and overflow (`DEPTH`=16):** push 8'h00..8'h0F → `full`=1, `count`=16. Push 8'hFF → dropped, `overflow`=1. Drain 16 pops → 8'h00..8'h0F in order.
- **Simultaneous push and pop when full:** push 8'h55 with `rd_en`=1 → `count` stays 16, `overflow` stays 0, and 8'h55 comes out last.
- **Read while empty, and push+read on an empty FIFO:** `rd_en`=1 while empty → `rd_valid`=0. Push 8'h33 with `rd_en` on the same cycle → `count`=1, and 8'h33 is still readable afterwards.
- **Overflow clear conflict and wrap-around:** `ovf_clr` on the same cycle as a drop → `overflow`=1. Then 40 push/pop pairs cross the pointer wrap → data order is preserved and `count` is correct throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter, the receiver and the receive FIFO.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the UART receive FIFO: synchronous write port, asynchronous read port.
// Holds no flags or pointers; the owner decides when a write is legal.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  uart_byte_t    wdata,
    input  logic [AW-1:0] raddr,
    output uart_byte_t    rdata
);

    uart_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: rx_status edge detect, pointer/flag logic, sticky overflow.
// Define UART_RX_FIFO_FWFT_EN for first-word-fall-through reads; otherwise rd_data is registered on pop.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  uart_byte_t    rx_data,
    input  logic          rx_status,
    input  logic          rd_en,
    output uart_byte_t    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam logic [AW:0] PTR_INC = (AW+1)'(1);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        st_d;
    logic        push;
    logic        pop;
    logic        wr_en;
    logic        drop;
    uart_byte_t  head;

    // st_d resets high so a done level already present at reset release is not taken as a new byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_d <= 1'b1;
        end else begin
            st_d <= rx_status;
        end
    end

    assign push  = rx_status & ~st_d;
    assign pop   = rd_en & ~empty;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;

    // A pop in the same cycle frees the slot, so a push while full is still accepted then.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_INC;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_INC;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

`ifdef UART_RX_FIFO_FWFT_EN
    // Head entry is shown while present; zero when empty keeps the output defined after reset.
    assign rd_data  = empty ? '0 : head;
    assign rd_valid = ~empty;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= head;
            end
        end
    end
`endif

endmodule
